std_fifo_packer: RTL and testbench
==================================

# std_fifo_packer

Read-side consumer for a `std_fifo` instance. It pops `IN_W`-bit entries, packs `RATIO` of them into one output word, and presents that word on a valid/ready stream to the next stage. An optional flush emits a partial word with a byte-keep mask. It sits directly downstream of the FIFO and drives the FIFO's `pop`.

## Interface
- `IN_W`, default 8: width of a FIFO entry (`fifo_q`).
- `RATIO`, default 4: number of entries per output word. Legal values are 2 to 16.
- `OUT_W`, default `IN_W*RATIO`: output word width. It is derived; do not override.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_pop` output, 1 bit: pop strobe to the FIFO.
- `fifo_q` input, `IN_W` bits: FIFO read data, valid the cycle after `fifo_pop`.
- `flush` input, 1 bit: single-cycle request to emit a partial word.
- `out_valid` output, 1 bit: output word valid.
- `out_ready` input, 1 bit: downstream accepts the word.
- `out_data` output, `OUT_W` bits: packed word.
- `out_keep` output, `RATIO` bits: per-entry valid mask. Bit i covers `out_data[i*IN_W +: IN_W]`.

## Operation
- State is held in these registers:
  - `acc` (`RATIO-1` entries) and `acc_cnt` (0 to `RATIO-1`).
  - `inflight`: a pop was issued last cycle.
  - The output register: `out_data`, `out_keep`, `out_valid`.
  - `flush_pend`.
- Pop rule: `fifo_pop` is combinational and is 1 only when all of the following hold:
  - `rst` is 1;
  - `!fifo_empty`;
  - `acc_cnt + inflight < RATIO`;
  - `!flush_pend`;
  - no word is stalled.
- Capture: when `inflight` is 1, `fifo_q` is written into slot `acc_cnt`. The first entry popped goes to the least-significant slot, i.e. little-endian packing.
- Word completion: a capture into slot `RATIO-1` forms the full word from `acc` plus `fifo_q`.
  - If the output register is free (`!out_valid` or `out_ready`), the word loads into it with `out_keep` all ones, and `acc_cnt` goes to 0.
  - Otherwise the word is stalled: held complete in the accumulator, with pops blocked, until the output register frees. It then loads the following cycle.
- Output handshake: a word transfers on any cycle with `out_valid && out_ready`. `out_data` and `out_keep` stay stable while `out_valid && !out_ready`.
- Flush (when compiled in):
  - `flush` sets `flush_pend` and blocks new pops.
  - Once `inflight` is 0, if `acc_cnt > 0` and the output register is free, the partial word loads. Unfilled slots are 0 and `out_keep` has `acc_cnt` low bits set. `acc_cnt` then goes to 0 and `flush_pend` clears.
  - If `acc_cnt == 0` at that point, `flush_pend` clears and no word is emitted.
  - `flush` while `flush_pend` is already set is ignored.
- Reset (`rst` = 0 at a clock edge):
  - `acc_cnt`, `inflight` and `flush_pend` go to 0.
  - `out_valid`, `out_data` and `out_keep` go to 0.
  - `fifo_pop` is 0 while `rst` is 0.
  - A mid-operation reset discards the accumulator and any in-flight entry. That entry is lost; the FIFO has already advanced.

## Timing
- FIFO read latency is fixed at one cycle: pop in cycle n, `fifo_q` sampled at the end of cycle n+1.
- Sustained throughput with `out_ready` held at 1 is `RATIO` entries per `RATIO+1` cycles.
  - Example for `RATIO`=4: pops in cycles 0 to 3, no pop in cycle 4, `out_valid` rises in cycle 5, pops resume in cycle 5.
- Latency from the first pop to `out_valid` is `RATIO+1` cycles.
- Simultaneous transfer and new-word load: the output register reloads in the same cycle it is accepted, so there is no bubble.
- Flush latency to `out_valid` is at most 2 cycles with a free output register. The first cycle is taken only if a pop is in flight.
- `flush` arriving in the same cycle as the completing capture: the full word loads first. `flush_pend` then finds `acc_cnt` = 0 and clears with no word.

## Configuration
- `STD_FIFO_PACKER_FLUSH_EN` defined:
  - The flush logic and `flush_pend` are built.
  - `out_keep` reflects partial words.
- `STD_FIFO_PACKER_FLUSH_EN` undefined:
  - The `flush` port exists but is ignored, and `flush_pend` is constant 0.
  - `out_keep` is constant all ones whenever `out_valid` is 1, and 0 otherwise.
  - Partial words are never emitted.

## Test plan
- Reset: hold `rst`=0 for 10 cycles with a non-empty FIFO. Required: `fifo_pop`=0, `out_valid`=0, `out_data`=0, `out_keep`=0 throughout.
- Streaming: push 1..64 into an 8-bit `std_fifo` and hold `out_ready`=1. Required:
  - 16 words appear, the first being 0x04030201 and the last 0x403F3E3D;
  - `out_keep`=0xF on every word;
  - 80 cycles from the first pop to the last capture.
- Backpressure: same data with `out_ready`=0 for 20 cycles, then 1. Required:
  - `out_data` holds 0x04030201 stable;
  - pops stop after entries 5 to 8 are captured, with the word stalled;
  - no data is lost or duplicated afterwards.
- Flush: push 0xAA and 0xBB, wait 6 cycles, pulse `flush`. Required: one word 0x0000BBAA with `out_keep`=0x3. A second `flush` with the accumulator empty emits nothing.
- Flush race: pulse `flush` in the cycle the 4th entry is captured. Required: the full word is emitted with keep 0xF, followed by no extra word.
- Mid-operation reset: pull `rst` low after 2 entries are captured and 1 is in flight. Required: the next word after reset starts from the 4th FIFO entry. Entries 1 to 3 are discarded.

Source files
------------

// File: rtl/std_fifo_packer.sv
// Packs RATIO consecutive std_fifo entries (little-endian) into one valid/ready output word.
// Define STD_FIFO_PACKER_FLUSH_EN to build the partial-word flush path with a per-entry keep mask.
module std_fifo_packer #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 4,
  parameter int unsigned OUT_W = IN_W * RATIO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  input  logic [IN_W-1:0]   fifo_q,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [RATIO-1:0]  out_keep
);

  localparam int unsigned CW = $clog2(RATIO);

  logic [IN_W-1:0] acc [RATIO-1];
  logic [IN_W-1:0] tail;
  logic [CW-1:0]   acc_cnt;
  logic [CW:0]     fill;
  logic            inflight;
  logic            stalled;
  logic            flush_pend;
  logic            out_free;
  logic            cap_last;
  logic            load_full;
  logic            load_part;
  logic [OUT_W-1:0] full_word;

  assign out_free  = !out_valid || out_ready;
  assign fill      = {1'b0, acc_cnt} + {{CW{1'b0}}, inflight};
  assign fifo_pop  = rst && !fifo_empty && (fill < (CW+1)'(RATIO)) && !flush_pend && !stalled;
  assign cap_last  = inflight && (acc_cnt == CW'(RATIO - 1));
  assign load_full = out_free && (cap_last || stalled);

  // A stalled word keeps its last entry in tail so the accumulator stays RATIO-1 deep.
  always_comb begin
    full_word = '0;
    for (int unsigned i = 0; i < RATIO - 1; i++)
      full_word[i*IN_W +: IN_W] = acc[i];
    full_word[(RATIO-1)*IN_W +: IN_W] = stalled ? tail : fifo_q;
  end

`ifdef STD_FIFO_PACKER_FLUSH_EN
  logic [OUT_W-1:0] part_word;
  logic [RATIO-1:0] part_keep;
  logic [RATIO-1:0] keep_r;
  logic             flush_go;
  logic             flush_done;

  assign flush_go   = flush_pend && !inflight && !stalled;
  assign load_part  = flush_go && (acc_cnt != '0) && out_free;
  assign flush_done = flush_go && ((acc_cnt == '0) || out_free);

  always_comb begin
    part_word = '0;
    part_keep = '0;
    for (int unsigned i = 0; i < RATIO - 1; i++) begin
      if (i < 32'(acc_cnt)) begin
        part_word[i*IN_W +: IN_W] = acc[i];
        part_keep[i]              = 1'b1;
      end
    end
  end

  // A flush arriving on the cycle the pending one completes is dropped, not re-armed.
  always_ff @(posedge clk) begin
    if (!rst)
      flush_pend <= 1'b0;
    else if (flush_done)
      flush_pend <= 1'b0;
    else if (flush)
      flush_pend <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      keep_r <= '0;
    else if (load_full)
      keep_r <= '1;
    else if (load_part)
      keep_r <= part_keep;
  end

  assign out_keep = keep_r;
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign flush_pend   = 1'b0;
  assign load_part    = 1'b0;
  assign out_keep     = {RATIO{out_valid}};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_cnt  <= '0;
      inflight <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      inflight <= fifo_pop;
      if (load_full || load_part) begin
        acc_cnt <= '0;
        stalled <= 1'b0;
      end else if (cap_last) begin
        stalled <= 1'b1;
      end else if (inflight) begin
        acc_cnt <= acc_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight && !cap_last) begin
      for (int unsigned i = 0; i < RATIO - 1; i++)
        if (acc_cnt == CW'(i))
          acc[i] <= fifo_q;
    end
    if (cap_last && !out_free)
      tail <= fifo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_full) begin
      out_valid <= 1'b1;
      out_data  <= full_word;
`ifdef STD_FIFO_PACKER_FLUSH_EN
    end else if (load_part) begin
      out_valid <= 1'b1;
      out_data  <= part_word;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_std_fifo_packer.sv
// Scoreboard bench for std_fifo_packer with a behavioural one-cycle-latency FIFO in front.
// Flush expectations follow STD_FIFO_PACKER_FLUSH_EN the same way the design does.
module tb_std_fifo_packer;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;

  logic             clk        = 1'b0;
  logic             rst        = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_pop;
  logic [IN_W-1:0]  fifo_q     = '0;
  logic             flush      = 1'b0;
  logic             out_valid;
  logic             out_ready  = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;

  std_fifo_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_q     (fifo_q),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 clk = ~clk;

  logic [IN_W-1:0]  fq[$];
  logic [OUT_W-1:0] exp_data[$];
  logic [RATIO-1:0] exp_keep[$];
  int unsigned cyc       = 0;
  int unsigned pop_cnt   = 0;
  int unsigned first_pop = 0;
  int unsigned last_pop  = 0;
  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;

  // FIFO model: data appears on fifo_q the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_pop) begin
      n_checks++;
      if (fq.size() == 0) begin
        n_fail++;
        $display("FAIL pop_on_empty: fifo_pop=1 with fifo empty at cycle %0d, required 0", cyc);
      end else begin
        fifo_q <= fq.pop_front();
      end
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    cyc++;
  end

  always @(negedge clk) fifo_empty = (fq.size() == 0);

  logic             stall_seen = 1'b0;
  logic [OUT_W-1:0] stall_data = '0;
  logic [RATIO-1:0] stall_keep = '0;

  always @(negedge clk) begin
    if (rst && stall_seen) begin
      n_checks++;
      if (!out_valid || out_data !== stall_data || out_keep !== stall_keep) begin
        n_fail++;
        $display("FAIL stall_stable: valid=%0b data=%h keep=%h, required valid=1 data=%h keep=%h",
                 out_valid, out_data, out_keep, stall_data, stall_keep);
      end
    end
    if (rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_data.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: data=%h keep=%h, required no word", out_data, out_keep);
      end else begin
        logic [OUT_W-1:0] ed;
        logic [RATIO-1:0] ek;
        ed = exp_data.pop_front();
        ek = exp_keep.pop_front();
        if (out_data !== ed || out_keep !== ek) begin
          n_fail++;
          $display("FAIL word: data=%h keep=%h, required data=%h keep=%h", out_data, out_keep, ed, ek);
        end
      end
    end
    stall_seen = rst && out_valid && !out_ready;
    stall_data = out_data;
    stall_keep = out_keep;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [OUT_W-1:0] d, input logic [RATIO-1:0] k);
    exp_data.push_back(d);
    exp_keep.push_back(k);
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) fq.push_back(8'(i));
  endtask

  task automatic wait_drain(input int unsigned budget, input string name);
    int unsigned n = 0;
    while (exp_data.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (exp_data.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d words never appeared, required 0", name, exp_data.size());
      exp_data.delete();
      exp_keep.delete();
    end
  endtask

  task automatic restart();
    rst = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    fq.delete();
    tick(2);
    pop_cnt = 0;
  endtask

  initial begin
    // Reset held with a full FIFO
    push_range(1, 64);
    tick(1);
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst_pop",   32'(fifo_pop),  32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data",  out_data,       32'h0);
      check("rst_keep",  32'(out_keep),  32'h0);
    end
    tick(1);

    // Streaming, out_ready held high
    pop_cnt = 0;
    for (int unsigned k = 0; k < 16; k++)
      expect_word({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'hF);
    rst = 1'b1;
    wait_drain(200, "stream_drain");
    check("stream_pops", pop_cnt, 32'd64);
    check("stream_span", last_pop - first_pop + 2, 32'd80);

    // Backpressure for 20 cycles after reset release
    restart();
    push_range(1, 16);
    out_ready = 1'b0;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    expect_word(32'h0C0B0A09, 4'hF);
    expect_word(32'h100F0E0D, 4'hF);
    rst = 1'b1;
    tick(20);
    check("bp_pops_stalled", pop_cnt, 32'd8);
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_hold", out_data, 32'h04030201);
    out_ready = 1'b1;
    wait_drain(100, "bp_drain");
    check("bp_pops_total", pop_cnt, 32'd16);

    // Flush of a two-entry partial word, then a flush with nothing accumulated
    restart();
    rst = 1'b1;
    tick(2);
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    tick(6);
`ifdef STD_FIFO_PACKER_FLUSH_EN
    expect_word(32'h0000BBAA, 4'h3);
`endif
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain(20, "flush_drain");
    tick(8);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check("flush_empty_idle", 32'(out_valid), 32'h0);
    check("flush_pops", pop_cnt, 32'd2);

    // Flush in the same cycle as the completing capture
    restart();
    push_range(1, 4);
    tick(1);
    expect_word(32'h04030201, 4'hF);
    rst = 1'b1;
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain(20, "race_drain");
    tick(10);
    check("race_no_extra", 32'(out_valid), 32'h0);

    // Reset with two entries captured and the third in flight
    restart();
    push_range(1, 8);
    tick(1);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    expect_word(32'h07060504, 4'hF);
    rst = 1'b1;
    wait_drain(30, "mid_rst_drain");
    tick(10);
    check("mid_rst_pops", pop_cnt, 32'd8);
    check("mid_rst_idle", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
